// File: rtl/lebug_cfg_pkg.sv
// Shared framing definitions for the configId/configData reconfiguration bus.
// Transmitter and receiving blocks import this package so both ends agree
// on field ordering, the idle ID and the transmitter state encoding.
package lebug_cfg_pkg;

    // Firmware fields per chain, in the order they are framed on the bus
    localparam int FIELD_OP         = 0;
    localparam int FIELD_ADDR_RD    = 1;
    localparam int FIELD_COND       = 2;
    localparam int FIELD_CACHE      = 3;
    localparam int FIELD_CACHE_ADDR = 4;
    localparam int NUM_FIELDS       = 5;

    // configId value meaning "no block addressed"; never a valid target
    localparam logic [7:0] CFG_IDLE_ID = 8'd0;

    typedef enum logic [1:0] {
        CFG_TX_IDLE   = 2'd0,
        CFG_TX_HEADER = 2'd1,
        CFG_TX_DATA   = 2'd2,
        CFG_TX_DONE   = 2'd3
    } cfg_tx_state_t;

endpackage

// File: rtl/cfg_staging_regfile.sv
// Flop-based staging buffer for one block's firmware bytes.
// Built from discrete registers rather than RAM so that reset clears it.
module cfg_staging_regfile #(
    parameter int DEPTH  = 20,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] entries [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [7:0] entry_reg;

        // One byte of storage; written when the address decodes to this slot
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                entry_reg <= 8'h00;
            end else if (wr_en && (wr_addr == ADDR_W'(gi))) begin
                entry_reg <= wr_data;
            end
        end

        assign entries[gi] = entry_reg;
    end

    // Combinational read; addresses past the end read as zero
    assign rd_data = (32'(rd_addr) < DEPTH) ? entries[rd_addr] : 8'h00;

endmodule

// File: rtl/firmware_config_transmitter.sv
// Broadcasts one block's staged firmware bytes as a framed stream on the
// configId/configData bus (header = payload length, then LEN payload bytes),
// and gates pipeline tracing while a frame is in flight.
module firmware_config_transmitter
    import lebug_cfg_pkg::*;
#(
    parameter int MAX_CHAINS = 4,
    parameter int NUM_FIELDS = lebug_cfg_pkg::NUM_FIELDS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          fw_wr_en,
    input  logic [$clog2(NUM_FIELDS)-1:0] fw_wr_field,
    input  logic [$clog2(MAX_CHAINS)-1:0] fw_wr_chain,
    input  logic [7:0]                    fw_wr_data,
    input  logic                          start,
    input  logic [7:0]                    target_id,
    input  logic                          tracing_in,
    output logic [7:0]                    configId,
    output logic [7:0]                    configData,
    output logic                          tracing,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam int LEN    = MAX_CHAINS * NUM_FIELDS;
    localparam int ADDR_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [7:0]        LEN_BYTE  = 8'(LEN);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LEN - 1);

    cfg_tx_state_t     state_reg, state_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;
    logic [7:0]        id_reg, id_next;

    logic [7:0]        config_id_reg;
    logic [7:0]        config_data_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              err_reg;
    logic              tracing_reg;

    logic              field_ok;
    logic              chain_ok;
    logic              wr_ok;
    logic              wr_reject;
    logic              start_reject;
    logic              in_frame;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        rd_data;

    // Write qualification: only in IDLE and only for in-range field/chain.
    // Field-major addressing puts all chains of one field next to each other.
    always_comb begin
        field_ok     = (32'(fw_wr_field) < NUM_FIELDS);
        chain_ok     = (32'(fw_wr_chain) < MAX_CHAINS);
        wr_ok        = fw_wr_en && (state_reg == CFG_TX_IDLE) && field_ok && chain_ok;
        wr_reject    = fw_wr_en && !wr_ok;
        start_reject = start && (state_reg == CFG_TX_IDLE) && (target_id == CFG_IDLE_ID);
        wr_addr      = ADDR_W'(32'(fw_wr_field) * MAX_CHAINS + 32'(fw_wr_chain));
        in_frame     = (state_reg == CFG_TX_HEADER) || (state_reg == CFG_TX_DATA);
    end

    cfg_staging_regfile #(
        .DEPTH  (LEN),
        .ADDR_W (ADDR_W)
    ) u_staging (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_ok),
        .wr_addr (wr_addr),
        .wr_data (fw_wr_data),
        .rd_addr (cnt_reg),
        .rd_data (rd_data)
    );

    // State, byte counter and latched target ID
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= CFG_TX_IDLE;
            cnt_reg   <= '0;
            id_reg    <= CFG_IDLE_ID;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            id_reg    <= id_next;
        end
    end

    // Frame sequencing: IDLE -> HEADER -> DATA (LEN bytes) -> DONE -> IDLE
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        id_next    = id_reg;
        case (state_reg)
            CFG_TX_IDLE: begin
                if (start && (target_id != CFG_IDLE_ID)) begin
                    id_next    = target_id;
                    state_next = CFG_TX_HEADER;
                end
            end
            CFG_TX_HEADER: begin
                cnt_next   = '0;
                state_next = CFG_TX_DATA;
            end
            CFG_TX_DATA: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST_ADDR) begin
                    state_next = CFG_TX_DONE;
                end
            end
            CFG_TX_DONE: begin
                state_next = CFG_TX_IDLE;
            end
            default: begin
                state_next = CFG_TX_IDLE;
            end
        endcase
    end

    // Registered bus and status outputs; the bus is forced to 0 outside a frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            config_id_reg   <= CFG_IDLE_ID;
            config_data_reg <= 8'h00;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            err_reg         <= 1'b0;
            tracing_reg     <= 1'b0;
        end else begin
            config_id_reg   <= in_frame ? id_reg : CFG_IDLE_ID;
            config_data_reg <= (state_reg == CFG_TX_HEADER) ? LEN_BYTE :
                               (state_reg == CFG_TX_DATA)   ? rd_data  : 8'h00;
            busy_reg        <= in_frame;
            done_reg        <= (state_reg == CFG_TX_DONE);
            err_reg         <= wr_reject || start_reject;
            tracing_reg     <= tracing_in && !busy_reg && !done_reg;
        end
    end

    assign configId   = config_id_reg;
    assign configData = config_data_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign err        = err_reg;
    assign tracing    = tracing_reg;

endmodule

// File: tb/tb_firmware_config_transmitter.sv
// Randomised and directed bench for firmware_config_transmitter. A
// timeline-based reference model predicts every bus cycle from the frame
// start edge and a snapshot of the staged bytes.
module tb_firmware_config_transmitter;
    import lebug_cfg_pkg::*;

    localparam int MC   = 4;
    localparam int NF   = 5;
    localparam int LEN  = MC * NF;
    localparam int LOGN = 4096;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fw_wr_en;
    logic [2:0] fw_wr_field;
    logic [1:0] fw_wr_chain;
    logic [7:0] fw_wr_data;
    logic       start;
    logic [7:0] target_id;
    logic       tracing_in;
    logic [7:0] configId;
    logic [7:0] configData;
    logic       tracing;
    logic       busy;
    logic       done;
    logic       err;

    always #5 clk = ~clk;

    firmware_config_transmitter #(
        .MAX_CHAINS (MC),
        .NUM_FIELDS (NF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fw_wr_en    (fw_wr_en),
        .fw_wr_field (fw_wr_field),
        .fw_wr_chain (fw_wr_chain),
        .fw_wr_data  (fw_wr_data),
        .start       (start),
        .target_id   (target_id),
        .tracing_in  (tracing_in),
        .configId    (configId),
        .configData  (configData),
        .tracing     (tracing),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    int         edge_n;
    int         fstart;
    logic [7:0] mbuf [LEN];
    logic [7:0] snap [LEN];
    logic [7:0] fid;
    logic       prev_busy, prev_done;

    // Per-edge log of observed DUT outputs for directed checks
    logic [7:0] log_id   [LOGN];
    logic [7:0] log_data [LOGN];
    logic       log_busy [LOGN];
    logic       log_done [LOGN];
    logic       log_err  [LOGN];
    logic       log_trc  [LOGN];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fstart    = -1000;
        prev_busy = 1'b0;
        prev_done = 1'b0;
        for (int i = 0; i < LEN; i++) mbuf[i] = 8'h00;
    endtask

    // Apply one cycle of inputs, update the model at the edge, compare after it
    task automatic step(input logic we, input logic [2:0] fld, input logic [1:0] ch,
                        input logic [7:0] d, input logic st, input logic [7:0] tid,
                        input logic tr);
        logic       idle, rej, e_busy, e_done, e_trc;
        logic [7:0] e_id, e_data;
        int         t;
        fw_wr_en    = we;
        fw_wr_field = fld;
        fw_wr_chain = ch;
        fw_wr_data  = d;
        start       = st;
        target_id   = tid;
        tracing_in  = tr;
        @(posedge clk);
        edge_n++;
        idle = (edge_n - fstart) >= LEN + 3;
        rej  = 1'b0;
        if (we) begin
            if (!idle || int'(fld) >= NF) rej = 1'b1;
            else mbuf[int'(fld) * MC + int'(ch)] = d;
        end
        if (st && idle) begin
            if (tid == 8'd0) begin
                rej = 1'b1;
            end else begin
                fstart = edge_n;
                fid    = tid;
                for (int i = 0; i < LEN; i++) snap[i] = mbuf[i];
            end
        end
        t      = edge_n - fstart;
        e_id   = 8'd0;
        e_data = 8'd0;
        e_busy = 1'b0;
        e_done = 1'b0;
        if (t == 1) begin
            e_id = fid; e_data = 8'(LEN); e_busy = 1'b1;
        end else if (t >= 2 && t <= LEN + 1) begin
            e_id = fid; e_data = snap[t - 2]; e_busy = 1'b1;
        end else if (t == LEN + 2) begin
            e_done = 1'b1;
        end
        e_trc     = tr & ~prev_busy & ~prev_done;
        prev_busy = e_busy;
        prev_done = e_done;
        #1;
        check_val($sformatf("bus@%0d", edge_n),
                  {configId, configData, busy, done, err, tracing},
                  {e_id, e_data, e_busy, e_done, rej, e_trc});
        if (edge_n < LOGN) begin
            log_id[edge_n]   = configId;
            log_data[edge_n] = configData;
            log_busy[edge_n] = busy;
            log_done[edge_n] = done;
            log_err[edge_n]  = err;
            log_trc[edge_n]  = tracing;
        end
    endtask

    task automatic idle_n(input int n, input logic tr);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 2'd0, 8'd0, 1'b0, 8'd0, tr);
    endtask

    task automatic send(input logic [7:0] tid, output int k);
        step(1'b0, 3'd0, 2'd0, 8'd0, 1'b1, tid, 1'b1);
        k = edge_n;
    endtask

    int k, k2, k3, k4, k5, k6, k7, e, r1, r2, cnt_b, cnt_i;
    logic [7:0] acc;

    initial begin
        rst_n = 1'b0; fw_wr_en = 1'b0; fw_wr_field = '0; fw_wr_chain = '0;
        fw_wr_data = '0; start = 1'b0; target_id = '0; tracing_in = 1'b0;
        edge_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_state", {configId, configData, busy, done, err, tracing}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Stage and send, with tracing held high
        step(1'b1, 3'(FIELD_OP), 2'd0, 8'd1, 1'b0, 8'd0, 1'b1);
        step(1'b1, 3'(FIELD_OP), 2'd1, 8'd2, 1'b0, 8'd0, 1'b1);
        step(1'b1, 3'(FIELD_OP), 2'd2, 8'd3, 1'b0, 8'd0, 1'b1);
        step(1'b1, 3'(FIELD_OP), 2'd3, 8'd0, 1'b0, 8'd0, 1'b1);
        step(1'b1, 3'(FIELD_CACHE_ADDR), 2'd2, 8'd7, 1'b0, 8'd0, 1'b1);
        send(8'd5, k);
        idle_n(LEN + 4, 1'b1);
        check_val("hdr_id", log_id[k + 1], 8'd5);
        check_val("hdr_len", log_data[k + 1], 8'd20);
        check_val("byte0", log_data[k + 2], 8'd1);
        check_val("byte18", log_data[k + 20], 8'd7);
        check_val("done_late", log_done[k + 22], 1'b1);
        check_val("done_early", log_done[k + 21], 1'b0);
        cnt_b = 0; cnt_i = 0;
        for (int i = k; i <= k + 24; i++) begin
            if (log_busy[i]) cnt_b++;
            if (log_id[i] != 8'd0) cnt_i++;
        end
        check_val("busy_cycles", cnt_b, LEN + 1);
        check_val("id_cycles", cnt_i, LEN + 1);
        check_val("trc_pre", log_trc[k + 1], 1'b1);
        check_val("trc_drop", log_trc[k + 2], 1'b0);
        check_val("trc_hold", log_trc[k + 23], 1'b0);
        check_val("trc_back", log_trc[k + 24], 1'b1);

        // Reserved target ID and out-of-range field
        step(1'b0, 3'd0, 2'd0, 8'd0, 1'b1, 8'd0, 1'b1);
        check_val("rsv_err", log_err[edge_n], 1'b1);
        step(1'b1, 3'd6, 2'd1, 8'h55, 1'b0, 8'd0, 1'b1);
        check_val("oor_err", log_err[edge_n], 1'b1);
        idle_n(2, 1'b1);

        // Write while busy is dropped
        send(8'd3, k2);
        idle_n(4, 1'b1);
        step(1'b1, 3'(FIELD_OP), 2'd0, 8'd9, 1'b0, 8'd0, 1'b1);
        check_val("busy_wr_err", log_err[edge_n], 1'b1);
        idle_n(LEN, 1'b1);
        check_val("busy_wr_b0", log_data[k2 + 2], 8'd1);
        send(8'd3, k3);
        idle_n(LEN + 3, 1'b1);
        check_val("repeat_b0", log_data[k3 + 2], 8'd1);

        // Back-to-back frames with a same-cycle write on the second start
        send(8'd7, k4);
        idle_n(LEN + 2, 1'b1);
        step(1'b1, 3'(FIELD_ADDR_RD), 2'd3, 8'hAB, 1'b1, 8'd9, 1'b1);
        k5 = edge_n;
        idle_n(LEN + 3, 1'b1);
        r1 = -1; r2 = -1;
        for (e = k4; e <= k5 + 4; e++) begin
            if (log_busy[e] && !log_busy[e - 1]) begin
                if (r1 < 0) r1 = e;
                else if (r2 < 0) r2 = e;
            end
        end
        check_val("b2b_period", r2 - r1, LEN + 3);
        check_val("b2b_same_wr", log_data[k5 + 2 + FIELD_ADDR_RD * MC + 3], 8'hAB);

        // Asynchronous reset in the middle of a frame
        send(8'd4, k6);
        idle_n(12, 1'b1);
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_id", configId, 8'd0);
        check_val("rst_mid_bus", {configId, configData, busy, done, err, tracing}, 32'h0);
        model_reset();
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        rst_n = 1'b1;
        send(8'd6, k7);
        idle_n(LEN + 3, 1'b1);
        acc = 8'h00;
        for (int i = 0; i < LEN; i++) acc = acc | log_data[k7 + 2 + i];
        check_val("post_rst_payload", acc, 8'h00);
        check_val("post_rst_hdr", log_data[k7 + 1], 8'd20);

        // Randomised traffic
        for (int i = 0; i < 900; i++) begin
            logic       we, st, tr;
            logic [2:0] fld;
            logic [1:0] ch;
            logic [7:0] d, tid;
            we  = ($urandom_range(0, 2) == 0);
            fld = 3'($urandom_range(0, 7));
            ch  = 2'($urandom_range(0, 3));
            d   = 8'($urandom_range(0, 255));
            st  = ($urandom_range(0, 9) == 0);
            tid = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            tr  = ($urandom_range(0, 7) != 0);
            step(we, fld, ch, d, st, tid, tr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
